branch_sequencer: RTL
=====================

Name: branch_sequencer

Overview:
- Owns the program counter and sequences it using the resolved output of branch_top.
- Accepts one branch resolution per handshake and computes the next PC for conditional branches (IDs 15-20) and jumps (IDs 21-23).
- Drives a fixed-length pipeline flush on every redirect and produces the $31 link write for jal.
- Sits between the instruction-decode stage / branch_top and the instruction fetch stage.

Parameters:
- PC_W, 32, width of the PC and of all address/offset buses.
- RESET_PC, 0, PC value loaded on reset.
- FLUSH_CYCLES, 2, number of cycles flush stays asserted after a redirect (legal range 1..15).
- LINK_REG, 31, register index written by jal.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold the PC this cycle (fetch back-pressure).
- halt  in  1  enter HALT; the block leaves HALT only on reset.
- br_valid  in  1  a branch resolution is presented.
- br_ready  out  1  the block can accept a resolution this cycle.
- br_id  in  32  instruction ID from decode; 15 beq, 16 bne, 17 bgt, 18 bgte, 19 ble, 20 bleq, 21 j, 22 jr, 23 jal.
- br_out  in  PC_W  branch_top out: signed offset for 15-20 (0 = not taken), absolute target for 21-23.
- br_pc  in  PC_W  PC of the branch instruction.
- pc  out  PC_W  current fetch PC.
- flush  out  1  squash younger instructions in the pipe.
- link_we  out  1  one-cycle register-file write strobe.
- link_addr  out  5  equals LINK_REG.
- link_data  out  PC_W  br_pc + 1.
- bad_id  out  1  one-cycle pulse when an unknown ID is accepted.
- taken_cnt  out  16  count of redirects taken; saturates at 0xFFFF.

Behaviour:
- Reset values: pc = RESET_PC, state = RUN, flush = 0, link_we = 0, bad_id = 0, taken_cnt = 0, flush counter = 0. Reset mid-flush or in HALT aborts immediately; reset wins over every other input.
- States: RUN, FLUSH, HALT.
- br_ready = (state == RUN) && !halt. Handshake fires when br_valid && br_ready. br_valid is ignored when br_ready is low; the requester holds its inputs until the handshake fires.
- Target computation, combinational and registered at the handshake edge:
  - IDs 15-20: target = br_pc + 1 + signed br_out.
  - IDs 21-23: target = br_out.
  - Arithmetic is modulo 2^PC_W; wrap-around is legal and is not flagged.
- Redirect: on a handshake, if (ID 15-20 and br_out != 0) or ID 21-23:
  - pc <= target;
  - state <= FLUSH; flush counter <= FLUSH_CYCLES - 1;
  - flush = 1 from the next cycle;
  - taken_cnt increments.
- No redirect: a handshake with ID 15-20 and br_out == 0 behaves as a sequential step; pc follows the stall rule.
- jal (ID 23): link_we = 1 for exactly the cycle after the handshake, with link_addr = LINK_REG and link_data = br_pc + 1.
- Unknown ID: the handshake completes; bad_id pulses 1 cycle; the PC is unaffected.
- RUN without a handshake: pc <= pc + 1 unless stall; the PC is held when stall = 1.
- FLUSH:
  - pc is held regardless of stall; br_ready = 0; flush = 1.
  - The counter decrements each cycle; at 0 the state goes to RUN and flush drops on the following cycle.
  - Total flush assertion is exactly FLUSH_CYCLES cycles.
- HALT: entered from RUN or FLUSH when halt = 1. halt takes priority over a same-cycle br_valid, which is not accepted. In HALT, pc is frozen, flush = 0, br_ready = 0.
- Simultaneous handshake and stall: the handshake wins and the PC redirects.
- taken_cnt holds at 0xFFFF once saturated.

Decomposition:
- Shared package branch_pkg:
  - ID localparams ID_BEQ = 15 through ID_JAL = 23;
  - state encoding RUN/FLUSH/HALT;
  - predicate functions is_cond(id) and is_jump(id).
- One sub-module, branch_target_calc: combinational target, redirect flag and link_data from br_id, br_out and br_pc. The FSM, PC register and counters live in the top level.

Test Plan:
- Reset, then 5 free-running cycles with stall = 0 -> pc = 0,1,2,3,4; flush = 0; br_ready = 1.
- beq not taken: br_id = 15, br_pc = 10, br_out = 0 -> no flush, pc keeps incrementing, taken_cnt = 0.
- bgte taken: br_id = 18, br_pc = 10, br_out = 99 -> pc = 110 the next cycle, flush high exactly 2 cycles, br_ready low for those 2 cycles, taken_cnt = 1.
- jal: br_id = 23, br_pc = 40, br_out = 100 -> pc = 100, link_we pulses once with link_addr = 31 and link_data = 41, flush for 2 cycles.
- Backward wrap: br_id = 16, br_pc = 0, br_out = -2 -> pc = 0xFFFFFFFF, no error. br_id = 7 -> bad_id pulses, pc unaffected.
- Priority:
  - halt together with br_valid -> not accepted and pc frozen;
  - reset asserted in the middle of FLUSH -> pc = 0, flush = 0, state RUN the next cycle;
  - stall during FLUSH -> pc held, flush length unchanged.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared IDs, state encoding and ID-class predicates for the branch sequencer.
package branch_pkg;

  localparam logic [31:0] ID_BEQ  = 32'd15;
  localparam logic [31:0] ID_BNE  = 32'd16;
  localparam logic [31:0] ID_BGT  = 32'd17;
  localparam logic [31:0] ID_BGTE = 32'd18;
  localparam logic [31:0] ID_BLE  = 32'd19;
  localparam logic [31:0] ID_BLEQ = 32'd20;
  localparam logic [31:0] ID_J    = 32'd21;
  localparam logic [31:0] ID_JR   = 32'd22;
  localparam logic [31:0] ID_JAL  = 32'd23;

  localparam int FLUSH_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } seq_state_e;

  function automatic logic is_cond(input logic [31:0] id);
    return (id >= ID_BEQ) && (id <= ID_BLEQ);
  endfunction

  function automatic logic is_jump(input logic [31:0] id);
    return (id >= ID_J) && (id <= ID_JAL);
  endfunction

endpackage

// File: rtl/branch_target_calc.sv
// Combinational next-PC target, redirect decision and jal link value for one
// branch resolution.
module branch_target_calc
  import branch_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic [31:0]     br_id,
  input  logic [PC_W-1:0] br_out,
  input  logic [PC_W-1:0] br_pc,
  output logic [PC_W-1:0] target,
  output logic            redirect,
  output logic            jal,
  output logic            unknown,
  output logic [PC_W-1:0] link_data
);

  logic [PC_W-1:0] seq_pc;
  logic            cond;
  logic            jump;

  always_comb begin
    seq_pc    = br_pc + PC_W'(1);
    cond      = is_cond(br_id);
    jump      = is_jump(br_id);
    // Offsets are two's complement, so a plain modulo add handles both directions.
    target    = jump ? br_out : (seq_pc + br_out);
    redirect  = (cond && (br_out != '0)) || jump;
    jal       = (br_id == ID_JAL);
    unknown   = !cond && !jump;
    link_data = seq_pc;
  end

endmodule

// File: rtl/branch_sequencer.sv
// Program-counter owner: applies branch_top resolutions, drives a fixed-length
// flush after each redirect and emits the jal link write.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_RUN   | fetching; accepts a resolution when !halt
// ST_FLUSH | redirect taken; pc held, flush high, counter running down
// ST_HALT  | frozen until reset
module branch_sequencer
  import branch_pkg::*;
#(
  parameter int              PC_W         = 32,
  parameter logic [PC_W-1:0] RESET_PC     = '0,
  parameter int              FLUSH_CYCLES = 2,
  parameter int              LINK_REG     = 31
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            halt,
  input  logic            br_valid,
  output logic            br_ready,
  input  logic [31:0]     br_id,
  input  logic [PC_W-1:0] br_out,
  input  logic [PC_W-1:0] br_pc,
  output logic [PC_W-1:0] pc,
  output logic            flush,
  output logic            link_we,
  output logic [4:0]      link_addr,
  output logic [PC_W-1:0] link_data,
  output logic            bad_id,
  output logic [15:0]     taken_cnt
);

  seq_state_e             state_q, state_d;
  logic [PC_W-1:0]        pc_q, pc_d;
  logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic                   link_we_q, link_we_d;
  logic [PC_W-1:0]        link_data_q, link_data_d;
  logic                   bad_id_q, bad_id_d;
  logic [15:0]            taken_cnt_q, taken_cnt_d;

  logic [PC_W-1:0] calc_target;
  logic            calc_redirect;
  logic            calc_jal;
  logic            calc_unknown;
  logic [PC_W-1:0] calc_link_data;
  logic            handshake;

  branch_target_calc #(
    .PC_W (PC_W)
  ) u_target_calc (
    .br_id     (br_id),
    .br_out    (br_out),
    .br_pc     (br_pc),
    .target    (calc_target),
    .redirect  (calc_redirect),
    .jal       (calc_jal),
    .unknown   (calc_unknown),
    .link_data (calc_link_data)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    flush_cnt_d = flush_cnt_q;
    link_we_d   = 1'b0;
    link_data_d = link_data_q;
    bad_id_d    = 1'b0;
    taken_cnt_d = taken_cnt_q;

    br_ready  = (state_q == ST_RUN) && !halt;
    handshake = br_valid && br_ready;

    unique case (state_q)
      ST_RUN: begin
        if (halt) begin
          state_d = ST_HALT;
        end else if (handshake) begin
          link_we_d   = calc_jal;
          link_data_d = calc_link_data;
          bad_id_d    = calc_unknown;
          // A redirect beats stall; a non-redirecting handshake is a plain step.
          if (calc_redirect) begin
            pc_d        = calc_target;
            state_d     = ST_FLUSH;
            flush_cnt_d = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
            if (taken_cnt_q != 16'hFFFF) begin
              taken_cnt_d = taken_cnt_q + 16'd1;
            end
          end else if (!stall) begin
            pc_d = pc_q + PC_W'(1);
          end
        end else if (!stall) begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      ST_FLUSH: begin
        if (halt) begin
          state_d     = ST_HALT;
          flush_cnt_d = '0;
        end else if (flush_cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          flush_cnt_d = flush_cnt_q - FLUSH_CNT_W'(1);
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      pc_q        <= RESET_PC;
      flush_cnt_q <= '0;
      link_we_q   <= 1'b0;
      link_data_q <= '0;
      bad_id_q    <= 1'b0;
      taken_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      flush_cnt_q <= flush_cnt_d;
      link_we_q   <= link_we_d;
      link_data_q <= link_data_d;
      bad_id_q    <= bad_id_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign pc        = pc_q;
  assign flush     = (state_q == ST_FLUSH);
  assign link_we   = link_we_q;
  assign link_addr = 5'(LINK_REG);
  assign link_data = link_data_q;
  assign bad_id    = bad_id_q;
  assign taken_cnt = taken_cnt_q;

endmodule
